fp_divider_iter: RTL and testbench
==================================

FP_DIVIDER_ITER -- requirements
Module: fp_divider_iter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, total operand/result width.
REQ-002 SHALL have parameter E_WIDTH, default 8, exponent width.
REQ-003 SHALL have parameter M_WIDTH, default 23, stored mantissa width.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operands present.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port number_1  input  D_WIDTH  dividend, IEEE-754 single.
REQ-009 SHALL have port number_2  input  D_WIDTH  divisor, IEEE-754 single.
REQ-010 SHALL have port out_valid  output  1  number_out holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port number_out  output  D_WIDTH  quotient {sign, exponent, mantissa}.

Function
REQ-013 SHALL use FSM states IDLE, DIVIDE, NORM, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept on in_valid&in_ready, registering both operands, and go to DIVIDE (normal case) or DONE (special case).
REQ-015 SHALL set sign = sign1^sign2 for all results, including zero and infinity, except NaN.
REQ-016 Special cases, all decided in the accepting cycle: either exponent == 255 or 0/0 -> 0x7FC00000; dividend exponent 0 (zero/denormal, flushed) -> signed zero; divisor exponent 0 -> signed infinity (exponent 255, mantissa 0).
REQ-017 DIVIDE SHALL run restoring division of {1,m1} by {1,m2}, one quotient bit per cycle, exactly 25 cycles, 5-bit down-counter, producing q[24:0] with q[24] the integer bit.
REQ-018 NORM SHALL compute signed 10-bit e = exp1 - exp2 + 127; if q[24]=1, mantissa = q[23:1]; else mantissa = q[22:0] and e = e-1.
REQ-019 Rounding SHALL be truncation; remainder discarded.
REQ-020 NORM SHALL force signed infinity if e >= 255 and signed zero if e <= 0.
REQ-021 DONE SHALL hold out_valid=1 and number_out stable until out_ready=1, then return to IDLE on that edge.
REQ-022 Latency: normal path out_valid rises 27 edges after the accepting edge; special path, 1 edge after.
REQ-023 in_valid outside IDLE SHALL be ignored; no operand is overwritten mid-operation.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, number_out=0, counter=0, flags=0, from any state, aborting any operation in flight.

Configuration
REQ-025 With FP_DIV_FLAGS_EN defined, SHALL add output port flags, 4 bits, {invalid, div_by_zero, overflow, underflow}, valid with out_valid and held with number_out.
REQ-026 Flag sources: invalid from NaN result; div_by_zero from finite nonzero / zero; overflow from e >= 255; underflow from e <= 0.
REQ-027 Without FP_DIV_FLAGS_EN, port flags and all flag logic SHALL be absent; number_out is unchanged.

Structure
REQ-028 Shared package fpu_pkg SHALL hold width constants, BIAS=127, QNAN=0x7FC00000, POS_INF=0x7F800000, FSM state typedef.
REQ-029 Sub-module fp_div_mantissa_core SHALL hold the 25-step restoring divider with start/done; FSM, exponent and special cases stay in the top.

Verification
REQ-030 0x40C00000 / 0x40000000 (6/2) -> 0x40400000 after 27 edges.
REQ-031 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated), NORM shift path.
REQ-032 0x3F800000 / 0x00000000 -> 0x7F800000 after 1 edge, div_by_zero=1; 0x80000000 / 0x40A00000 -> 0x80000000; 0/0 -> 0x7FC00000, invalid=1.
REQ-033 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow=1; 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
REQ-034 out_ready held 0 for 10 cycles after out_valid: number_out stable, in_ready=0; out_ready=1 -> IDLE next edge, back-to-back operation correct.
REQ-035 rst_n=0 at DIVIDE cycle 12 -> IDLE, out_valid=0; next operation 6/2 correct.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and FSM state type for the iterative FP divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_pkg;

    localparam int D_W  = 32;
    localparam int E_W  = 8;
    localparam int M_W  = 23;
    localparam int BIAS = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fp_div_mantissa_core.sv
// Restoring divider of {1,man_a} by {1,man_b}, one quotient bit per cycle.
// Latency: loads on start, then M_WIDTH+2 iteration cycles; done flags the last one.
// Backpressure: none; start reloads unconditionally, quotient held until next start.
module fp_div_mantissa_core #(
    parameter int M_WIDTH = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [M_WIDTH-1:0] man_a,
    input  logic [M_WIDTH-1:0] man_b,
    output logic               done,
    output logic [M_WIDTH+1:0] quot
);

    localparam int QW = M_WIDTH + 2;

    // Partial remainder stays below twice the divisor, so QW bits suffice.
    logic [QW-1:0]      rem;
    logic [M_WIDTH:0]   dvs;
    logic [4:0]         cnt;
    logic [QW-1:0]      diff;
    logic               ge;

    // Trial subtraction for the current quotient bit.
    always_comb begin
        ge   = (rem >= {1'b0, dvs});
        diff = rem - {1'b0, dvs};
    end

    // Done is raised during the cycle whose edge writes the final quotient bit.
    assign done = (cnt == 5'd1);

    // Load operands on start, then shift in one quotient bit per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            quot <= '0;
        end else if (start) begin
            rem  <= {1'b0, 1'b1, man_a};
            dvs  <= {1'b1, man_b};
            cnt  <= 5'(QW);
            quot <= '0;
        end else if (cnt != 5'd0) begin
            quot <= {quot[QW-2:0], ge};
            rem  <= ge ? {diff[QW-2:0], 1'b0} : {rem[QW-2:0], 1'b0};
            cnt  <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/fp_divider_iter.sv
// Iterative IEEE-754 single divider (truncating, denormals flushed); optional flags via FP_DIV_FLAGS_EN.
// Latency: 27 edges incl. accepting edge for normal operands, 1 edge for special cases.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module fp_divider_iter
    import fpu_pkg::*;
#(
    parameter int D_WIDTH = D_W,
    parameter int E_WIDTH = E_W,
    parameter int M_WIDTH = M_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] number_1,
    input  logic [D_WIDTH-1:0] number_2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] number_out
`ifdef FP_DIV_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);

    localparam int EW2 = E_WIDTH + 2;
    localparam logic [E_WIDTH-1:0]    EXP_MAX = '1;
    localparam logic signed [EW2-1:0] BIAS_S  = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EMAX_S  = EW2'((1 << E_WIDTH) - 1);

    state_t state, state_nxt;

    logic               sign_q;
    logic [E_WIDTH-1:0] exp_a, exp_b;

    logic               in_sign;
    logic [E_WIDTH-1:0] in_exp_a, in_exp_b;
    logic               accept, start;
    logic               is_nan, is_zero, is_inf, special;
    logic [D_WIDTH-1:0] special_res;

    logic               core_done;
    logic [M_WIDTH+1:0] quot;

    logic signed [EW2-1:0] e_raw, e_adj;
    logic [M_WIDTH-1:0]    man_n;
    logic                  ovf, unf;
    logic [D_WIDTH-1:0]    norm_res;

`ifdef FP_DIV_FLAGS_EN
    logic [3:0] flags_q;
    assign flags = flags_q;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign in_sign  = number_1[D_WIDTH-1] ^ number_2[D_WIDTH-1];
    assign in_exp_a = number_1[D_WIDTH-2 -: E_WIDTH];
    assign in_exp_b = number_2[D_WIDTH-2 -: E_WIDTH];
    assign accept   = (state == IDLE) && in_valid;
    assign start    = accept && !special;

    // Special-case classification on the raw inputs in the accepting cycle.
    always_comb begin
        is_nan  = (in_exp_a == EXP_MAX) || (in_exp_b == EXP_MAX) ||
                  ((in_exp_a == '0) && (in_exp_b == '0));
        is_zero = (in_exp_a == '0);
        is_inf  = (in_exp_b == '0);
        special = is_nan || is_zero || is_inf;
        if (is_nan) begin
            special_res = D_WIDTH'(QNAN);
        end else if (is_zero) begin
            special_res = {in_sign, {(D_WIDTH-1){1'b0}}};
        end else begin
            special_res = D_WIDTH'(POS_INF) | {in_sign, {(D_WIDTH-1){1'b0}}};
        end
    end

    fp_div_mantissa_core #(
        .M_WIDTH (M_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .man_a (number_1[M_WIDTH-1:0]),
        .man_b (number_2[M_WIDTH-1:0]),
        .done  (core_done),
        .quot  (quot)
    );

    // Exponent, one-bit normalisation and overflow/underflow clamping.
    always_comb begin
        e_raw = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_S;
        if (quot[M_WIDTH+1]) begin
            e_adj = e_raw;
            man_n = quot[M_WIDTH:1];
        end else begin
            e_adj = e_raw - EW2'(1);
            man_n = quot[M_WIDTH-1:0];
        end
        ovf = (e_adj >= EMAX_S);
        unf = e_adj[EW2-1] || (e_adj == '0);
        if (ovf) begin
            norm_res = D_WIDTH'(POS_INF) | {sign_q, {(D_WIDTH-1){1'b0}}};
        end else if (unf) begin
            norm_res = {sign_q, {(D_WIDTH-1){1'b0}}};
        end else begin
            norm_res = {sign_q, e_adj[E_WIDTH-1:0], man_n};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = special ? DONE : DIVIDE;
            DIVIDE:  if (core_done) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and result/flag registers, written only on accept or in NORM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q     <= 1'b0;
            exp_a      <= '0;
            exp_b      <= '0;
            number_out <= '0;
`ifdef FP_DIV_FLAGS_EN
            flags_q    <= '0;
`endif
        end else if (accept) begin
            sign_q <= in_sign;
            exp_a  <= in_exp_a;
            exp_b  <= in_exp_b;
            if (special) begin
                number_out <= special_res;
`ifdef FP_DIV_FLAGS_EN
                flags_q    <= {is_nan, !is_nan && !is_zero && is_inf, 2'b00};
`endif
            end
        end else if (state == NORM) begin
            number_out <= norm_res;
`ifdef FP_DIV_FLAGS_EN
            flags_q    <= {2'b00, ovf, unf};
`endif
        end
    end

endmodule

// File: tb/tb_fp_divider_iter.sv
// Directed bench for fp_divider_iter; flag checks compiled in with FP_DIV_FLAGS_EN.
// Latency: counts edges from the accepting edge (counted as 1) to out_valid.
// Backpressure: holds out_ready low to confirm the result is held stable.
module tb_fp_divider_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] number_1;
    logic [31:0] number_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] number_out;
`ifdef FP_DIV_FLAGS_EN
    logic [3:0]  flags;
`endif

    int checks   = 0;
    int failures = 0;

    fp_divider_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .number_1   (number_1),
        .number_2   (number_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .number_out (number_out)
`ifdef FP_DIV_FLAGS_EN
        ,
        .flags      (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One full operation: present operands, count edges to out_valid, check, handshake.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                         input int exp_lat, input logic [3:0] exp_flags, input string tag);
        int n;
        check({31'd0, in_ready}, 32'd1, {tag, "_in_ready"});
        number_1 = a;
        number_2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({31'd0, out_valid}, 32'd1, {tag, "_out_valid"});
        check(32'(n), 32'(exp_lat), {tag, "_latency"});
        check(number_out, expv, {tag, "_result"});
`ifdef FP_DIV_FLAGS_EN
        check({28'd0, flags}, {28'd0, exp_flags}, {tag, "_flags"});
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({31'd0, in_ready}, 32'd1, {tag, "_idle_after"});
        check({31'd0, out_valid}, 32'd0, {tag, "_ov_after"});
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        number_1  = '0;
        number_2  = '0;
        repeat (2) @(posedge clk);
        #1;
        check({31'd0, in_ready}, 32'd1, "rst_in_ready");
        check({31'd0, out_valid}, 32'd0, "rst_out_valid");
        check(number_out, 32'h0, "rst_number_out");
`ifdef FP_DIV_FLAGS_EN
        check({28'd0, flags}, 32'd0, "rst_flags");
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(32'h40C00000, 32'h40000000, 32'h40400000, 27, 4'b0000, "six_div_two");
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, 4'b0000, "one_div_three");
        do_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 27, 4'b0000, "neg_six_div_two");
        do_op(32'h3F800000, 32'h00000000, 32'h7F800000,  1, 4'b0100, "div_by_zero");
        do_op(32'h3F800000, 32'h80000000, 32'hFF800000,  1, 4'b0100, "div_by_neg_zero");
        do_op(32'h80000000, 32'h40A00000, 32'h80000000,  1, 4'b0000, "neg_zero_dividend");
        do_op(32'h00000000, 32'h00000000, 32'h7FC00000,  1, 4'b1000, "zero_div_zero");
        do_op(32'hFFC00000, 32'h3F800000, 32'h7FC00000,  1, 4'b1000, "nan_operand");
        do_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 27, 4'b0010, "overflow");
        do_op(32'h00800000, 32'h40000000, 32'h00000000, 27, 4'b0001, "underflow");

        // Backpressure, with a competing request held on the inputs mid-operation.
        number_1 = 32'h40C00000;
        number_2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        number_1 = 32'h3F800000;
        number_2 = 32'h40400000;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check(32'(n), 32'd27, "bp_latency");
        check(number_out, 32'h40400000, "bp_result");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check({31'd0, out_valid}, 32'd1, "bp_hold_valid");
            check(number_out, 32'h40400000, "bp_hold_data");
            check({31'd0, in_ready}, 32'd0, "bp_hold_in_ready");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({31'd0, in_ready}, 32'd1, "bp_release_idle");
        check({31'd0, out_valid}, 32'd0, "bp_release_ov");
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, 4'b0000, "back_to_back");

        // Reset during DIVIDE cycle 12 aborts the operation.
        number_1 = 32'h40C00000;
        number_2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check({31'd0, in_ready}, 32'd0, "mid_busy");
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check({31'd0, in_ready}, 32'd1, "mid_rst_idle");
        check({31'd0, out_valid}, 32'd0, "mid_rst_ov");
        check(number_out, 32'h0, "mid_rst_out");
        do_op(32'h40C00000, 32'h40000000, 32'h40400000, 27, 4'b0000, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
